count_game_core: RTL

Parametrised round engine for the counting game. It runs a configurable number of timed rounds. Each round draws a pseudo-random target, the player matches it on the switches and presses confirm, and the block keeps score. It sits between the board input conditioning (debounced buttons and switches) and the display drivers (seg/dig scanner, LED matrix, LED bar, buzzer), replacing the fixed 7-switch game logic with generic width, round count and timing.

---
 rtl/count_game_core_if.sv | 43 ++++
 rtl/count_game_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/count_game_core_if.sv
// count_game_core_if
//   Groups the game signals between the input conditioning / display side
//   and the round engine.
//   Ports (signals):
//     start, confirm  debounced button levels
//     sw              player answer, SW_W bits
//     target          current round's target, SW_W bits
//     score, round, time_left  8-bit game status
//     state           0 IDLE, 1 PLAY, 2 SHOW, 3 DONE
//     led             LED bar, LED_W bits
//     hit, miss       one-cycle answer pulses
//     game_over, beep DONE flag and buzzer enable
//   Modports: master = board/display side, slave = round engine.
interface count_game_core_if #(
   parameter int SW_W  = 7,
   parameter int LED_W = 16
);
   logic             start;
   logic             confirm;
   logic [SW_W-1:0]  sw;
   logic [SW_W-1:0]  target;
   logic [7:0]       score;
   logic [7:0]       round;
   logic [7:0]       time_left;
   logic [1:0]       state;
   logic [LED_W-1:0] led;
   logic             hit;
   logic             miss;
   logic             game_over;
   logic             beep;

   modport master (
      output start, confirm, sw,
      input  target, score, round, time_left, state, led,
             hit, miss, game_over, beep
   );

   modport slave (
      input  start, confirm, sw,
      output target, score, round, time_left, state, led,
             hit, miss, game_over, beep
   );
endinterface

// File: rtl/count_game_core.sv
// count_game_core
//   Round engine for the counting game: runs ROUNDS timed rounds, each with
//   a pseudo-random target the player matches on the switches and confirms.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous, active-low reset
//     gif  count_game_core_if.slave: start/confirm/sw in; target, score,
//          round, time_left, state, led, hit, miss, game_over, beep out.
//   All outputs are registered.
module count_game_core #(
   parameter int SW_W      = 7,
   parameter int TICK_DIV  = 1000,
   parameter int ROUND_SEC = 10,
   parameter int ROUNDS    = 8,
   parameter int BEEP_CYC  = 200,
   parameter int LED_W     = 16
) (
   input logic              clk,
   input logic              rst,
   count_game_core_if.slave gif
);
   localparam int TW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BEEP_CYC + 1);
   localparam logic [15:0] lfsr_seed = 16'hACE1;
   // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
   localparam logic [15:0] lfsr_taps = 16'hB400;

   typedef enum logic [1:0] {s_idle = 2'd0, s_play = 2'd1, s_show = 2'd2, s_done = 2'd3} state_t;

   state_t           state_reg, state_next;
   logic             start_q, confirm_q;
   logic [15:0]      lfsr_reg, lfsr_next;
   logic [SW_W-1:0]  target_reg, target_next;
   logic [7:0]       score_reg, score_next;
   logic [7:0]       round_reg, round_next;
   logic [7:0]       time_reg, time_next;
   logic [TW-1:0]    tick_reg, tick_next;
   logic [BW-1:0]    beep_cnt_reg, beep_cnt_next;
   logic             show_hit_reg, show_hit_next;
   logic             hit_reg, hit_next;
   logic             miss_reg, miss_next;
   logic             over_reg, over_next;
   logic             beep_reg, beep_next;
   logic [LED_W-1:0] led_reg, led_next;
   logic [LED_W-1:0] bar_time, bar_score;

   logic start_edge, confirm_edge, tick_last;
   assign start_edge   = gif.start & ~start_q;
   assign confirm_edge = gif.confirm & ~confirm_q;
   assign tick_last    = (tick_reg == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= s_idle;
         start_q      <= 1'b0;
         confirm_q    <= 1'b0;
         lfsr_reg     <= lfsr_seed;
         target_reg   <= '0;
         score_reg    <= '0;
         round_reg    <= '0;
         time_reg     <= '0;
         tick_reg     <= '0;
         beep_cnt_reg <= '0;
         show_hit_reg <= 1'b0;
         hit_reg      <= 1'b0;
         miss_reg     <= 1'b0;
         over_reg     <= 1'b0;
         beep_reg     <= 1'b0;
         led_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         start_q      <= gif.start;
         confirm_q    <= gif.confirm;
         lfsr_reg     <= lfsr_next;
         target_reg   <= target_next;
         score_reg    <= score_next;
         round_reg    <= round_next;
         time_reg     <= time_next;
         tick_reg     <= tick_next;
         beep_cnt_reg <= beep_cnt_next;
         show_hit_reg <= show_hit_next;
         hit_reg      <= hit_next;
         miss_reg     <= miss_next;
         over_reg     <= over_next;
         beep_reg     <= beep_next;
         led_reg      <= led_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      lfsr_next     = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? lfsr_taps : 16'h0000);
      target_next   = target_reg;
      score_next    = score_reg;
      round_next    = round_reg;
      time_next     = time_reg;
      tick_next     = tick_reg;
      show_hit_next = show_hit_reg;
      hit_next      = 1'b0;
      miss_next     = 1'b0;

      case (state_reg)
         s_idle, s_done: begin
            if (start_edge) begin
               state_next  = s_play;
               round_next  = 8'd1;
               score_next  = 8'd0;
               target_next = lfsr_reg[SW_W-1:0];
               time_next   = 8'(ROUND_SEC);
               tick_next   = '0;
            end
         end
         s_play: begin
            // A confirm edge wins over a coinciding final tick, so time_left
            // is left untouched on that path.
            if (confirm_edge) begin
               state_next = s_show;
               tick_next  = '0;
               if (gif.sw == target_reg) begin
                  hit_next      = 1'b1;
                  show_hit_next = 1'b1;
                  if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
               end else begin
                  miss_next     = 1'b1;
                  show_hit_next = 1'b0;
               end
            end else if (tick_last) begin
               tick_next = '0;
               time_next = time_reg - 8'd1;
               if (time_reg == 8'd1) begin
                  state_next    = s_show;
                  miss_next     = 1'b1;
                  show_hit_next = 1'b0;
               end
            end else begin
               tick_next = tick_reg + 1'b1;
            end
         end
         s_show: begin
            if (tick_last) begin
               tick_next = '0;
               if (round_reg == 8'(ROUNDS)) begin
                  state_next = s_done;
               end else begin
                  state_next  = s_play;
                  round_next  = round_reg + 8'd1;
                  target_next = lfsr_reg[SW_W-1:0];
                  time_next   = 8'(ROUND_SEC);
               end
            end else begin
               tick_next = tick_reg + 1'b1;
            end
         end
         default: state_next = s_idle;
      endcase

      over_next = (state_next == s_done);

      // beep follows the counter one cycle later, so it rises the cycle
      // after the hit pulse and lasts exactly BEEP_CYC cycles.
      beep_next     = (beep_cnt_reg != '0);
      beep_cnt_next = (beep_cnt_reg != '0) ? beep_cnt_reg - 1'b1 : beep_cnt_reg;
      if (hit_next || (state_next == s_done && state_reg != s_done))
         beep_cnt_next = BW'(BEEP_CYC);
   end

   // Thermometer bars for the remaining time and the final score
   genvar gi;
   generate
      for (gi = 0; gi < LED_W; gi++) begin : g_bar
         assign bar_time[gi]  = (8'(gi) < time_next);
         assign bar_score[gi] = (8'(gi) < score_next);
      end
   endgenerate

   always_comb begin
      led_next = '0;
      case (state_next)
         s_play:  led_next = bar_time;
         s_show:  led_next = {LED_W{show_hit_next}};
         s_done:  led_next = bar_score;
         default: led_next = '0;
      endcase
   end

   assign gif.target    = target_reg;
   assign gif.score     = score_reg;
   assign gif.round     = round_reg;
   assign gif.time_left = time_reg;
   assign gif.state     = state_reg;
   assign gif.led       = led_reg;
   assign gif.hit       = hit_reg;
   assign gif.miss      = miss_reg;
   assign gif.game_over = over_reg;
   assign gif.beep      = beep_reg;
endmodule
